// File: rtl/bp_me_pkg.sv
// Shared types and helpers for the BedRock stream memory responder:
// command header layout, message encodings, FSM states and beat-count math.
package bp_me_pkg;

  typedef enum logic [1:0] {
    e_bp_default_cfg = 2'd0
  } bp_params_e;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'b0000,
    e_bedrock_mem_wr    = 4'b0001,
    e_bedrock_mem_uc_rd = 4'b0010,
    e_bedrock_mem_uc_wr = 4'b0011,
    e_bedrock_mem_pre   = 4'b0100,
    e_bedrock_mem_amo   = 4'b0101
  } bp_bedrock_mem_type_e;

  typedef struct packed {
    logic [15:0] payload;
    logic [2:0]  size;
    logic [39:0] addr;
    logic [3:0]  msg_type;
  } bp_bedrock_mem_header_s;

  localparam int bp_mem_header_width_gp = $bits(bp_bedrock_mem_header_s);

  typedef enum logic [1:0] {
    e_ready = 2'd0,
    e_write = 2'd1,
    e_resp  = 2'd2
  } bp_me_stream_mem_state_e;

  function automatic int bp_data_width(bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return 64;
      default:          return 64;
    endcase
  endfunction

  // Message of (8 << size) bits split into data-width beats, never fewer than one.
  function automatic int unsigned bp_me_stream_beats(logic [2:0] size, int unsigned data_width);
    int unsigned bits;
    bits = 32'd8 << size;
    return (bits < data_width) ? 32'd1 : bits / data_width;
  endfunction

  function automatic logic bp_me_is_write(logic [3:0] msg_type);
    return (msg_type == e_bedrock_mem_wr) || (msg_type == e_bedrock_mem_uc_wr);
  endfunction

  function automatic logic bp_me_is_read(logic [3:0] msg_type);
    return (msg_type == e_bedrock_mem_rd) || (msg_type == e_bedrock_mem_uc_rd);
  endfunction

endpackage

// File: rtl/bp_me_stream_mem_responder_storage.sv
// Flop-array backing store: one byte-masked write port, one combinational read port.
// Contents are deliberately not reset.
module bp_me_stream_mem_storage #(
  parameter int data_width_p = 64,
  parameter int els_p        = 256,
  localparam int bytes_lp    = data_width_p / 8,
  localparam int lg_els_lp   = $clog2(els_p)
) (
  input  logic                    clk_i,
  input  logic                    w_v_i,
  input  logic [lg_els_lp-1:0]    w_addr_i,
  input  logic [bytes_lp-1:0]     w_mask_i,
  input  logic [data_width_p-1:0] w_data_i,
  input  logic [lg_els_lp-1:0]    r_addr_i,
  output logic [data_width_p-1:0] r_data_o
);

  logic [bytes_lp-1:0][7:0] mem_r [els_p];
  logic [bytes_lp-1:0][7:0] w_bytes;

  assign w_bytes = w_data_i;

  always_ff @(posedge clk_i) begin
    if (w_v_i) begin
      for (int i = 0; i < bytes_lp; i++) begin
        if (w_mask_i[i]) mem_r[w_addr_i][i] <= w_bytes[i];
      end
    end
  end

  assign r_data_o = mem_r[r_addr_i];

endmodule

// File: rtl/bp_me_stream_mem_responder.sv
// Memory-side endpoint of the BedRock stream CCE-MEM interface, backed by a flop array.
//   state   | meaning
//   e_ready | idle, accepting the first (or only) command beat
//   e_write | accepting further write data beats
//   e_resp  | driving response beats until the last one transfers
module bp_me_stream_mem_responder
  import bp_me_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_default_cfg,
  parameter int mem_els_p           = 256,
  localparam int data_width_lp       = bp_data_width(bp_params_p),
  localparam int mem_header_width_lp = bp_mem_header_width_gp
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic [mem_header_width_lp-1:0] mem_cmd_header_i,
  input  logic [data_width_lp-1:0]       mem_cmd_data_i,
  input  logic                           mem_cmd_v_i,
  output logic                           mem_cmd_ready_and_o,
  input  logic                           mem_cmd_last_i,
  output logic [mem_header_width_lp-1:0] mem_resp_header_o,
  output logic [data_width_lp-1:0]       mem_resp_data_o,
  output logic                           mem_resp_v_o,
  input  logic                           mem_resp_ready_and_i,
  output logic                           mem_resp_last_o,
  output logic                           error_o
);

  localparam int data_bytes_lp    = data_width_lp / 8;
  localparam int lg_data_bytes_lp = $clog2(data_bytes_lp);
  localparam int lg_els_lp        = $clog2(mem_els_p);
  localparam int cnt_width_lp     = $clog2(1024 / data_width_lp) + 1;

  bp_me_stream_mem_state_e state_r;
  bp_bedrock_mem_header_s  cmd_hdr, hdr_r, act_hdr;
  logic [cnt_width_lp-1:0] cnt_r, beat_k, n_beats;
  logic                    cmd_ready_r, resp_v_r, resp_last_r, error_r;

  logic [lg_els_lp-1:0]        base_idx, blk_mask, word_idx;
  logic [lg_data_bytes_lp-1:0] byte_off, sub_mask;
  logic [data_bytes_lp-1:0]    w_mask;
  logic [data_bytes_lp-1:0][7:0] cmd_bytes, mem_bytes, w_bytes, r_bytes;
  logic                        w_v, resp_is_read;

  assign cmd_hdr   = mem_cmd_header_i;
  assign cmd_bytes = mem_cmd_data_i;

  // In e_ready the incoming header addresses beat 0; afterwards the latched one drives.
  always_comb begin
    act_hdr  = (state_r == e_ready) ? cmd_hdr : hdr_r;
    beat_k   = (state_r == e_ready) ? '0 : cnt_r;
    n_beats  = cnt_width_lp'(bp_me_stream_beats(act_hdr.size, data_width_lp));
    base_idx = act_hdr.addr[lg_data_bytes_lp +: lg_els_lp];
    blk_mask = lg_els_lp'(n_beats - 1'b1);
    word_idx = (base_idx & ~blk_mask) | ((base_idx + lg_els_lp'(beat_k)) & blk_mask);
    byte_off = act_hdr.addr[lg_data_bytes_lp-1:0];
    if (act_hdr.size >= 3'(lg_data_bytes_lp)) begin
      sub_mask = '1;
    end else begin
      sub_mask = lg_data_bytes_lp'((32'd1 << act_hdr.size) - 32'd1);
    end
  end

  // Sub-word accesses: write lanes land at the aligned offset, read lanes replicate it.
  always_comb begin
    w_mask  = '0;
    w_bytes = '0;
    r_bytes = '0;
    for (int i = 0; i < data_bytes_lp; i++) begin
      w_mask[i]  = ((lg_data_bytes_lp'(i) & ~sub_mask) == (byte_off & ~sub_mask));
      w_bytes[i] = cmd_bytes[lg_data_bytes_lp'(i) & sub_mask];
      r_bytes[i] = mem_bytes[(lg_data_bytes_lp'(i) & sub_mask) | (byte_off & ~sub_mask)];
    end
  end

  assign w_v = mem_cmd_v_i & cmd_ready_r
             & (((state_r == e_ready) & bp_me_is_write(cmd_hdr.msg_type))
               | (state_r == e_write));

  bp_me_stream_mem_storage #(
    .data_width_p(data_width_lp),
    .els_p       (mem_els_p)
  ) storage (
    .clk_i   (clk_i),
    .w_v_i   (w_v),
    .w_addr_i(word_idx),
    .w_mask_i(w_mask),
    .w_data_i(w_bytes),
    .r_addr_i(word_idx),
    .r_data_o(mem_bytes)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r     <= e_ready;
      hdr_r       <= '0;
      cnt_r       <= '0;
      cmd_ready_r <= 1'b0;
      resp_v_r    <= 1'b0;
      resp_last_r <= 1'b0;
      error_r     <= 1'b0;
    end else begin
      case (state_r)
        e_ready: begin
          cmd_ready_r <= 1'b1;
          if (mem_cmd_v_i && cmd_ready_r) begin
            hdr_r <= cmd_hdr;
            cnt_r <= '0;
            if (bp_me_is_write(cmd_hdr.msg_type)) begin
              if (mem_cmd_last_i) begin
                state_r     <= e_resp;
                cmd_ready_r <= 1'b0;
                resp_v_r    <= 1'b1;
                resp_last_r <= 1'b1;
              end else begin
                state_r <= e_write;
                cnt_r   <= cnt_width_lp'(1);
              end
            end else begin
              state_r     <= e_resp;
              cmd_ready_r <= 1'b0;
              resp_v_r    <= 1'b1;
              resp_last_r <= (n_beats == cnt_width_lp'(1));
              if (!bp_me_is_read(cmd_hdr.msg_type)) error_r <= 1'b1;
            end
          end
        end
        e_write: begin
          if (mem_cmd_v_i) begin
            cnt_r <= cnt_r + 1'b1;
            if (mem_cmd_last_i) begin
              state_r     <= e_resp;
              cnt_r       <= '0;
              cmd_ready_r <= 1'b0;
              resp_v_r    <= 1'b1;
              resp_last_r <= 1'b1;
            end
          end
        end
        e_resp: begin
          if (mem_resp_ready_and_i) begin
            if (resp_last_r) begin
              state_r     <= e_ready;
              cnt_r       <= '0;
              cmd_ready_r <= 1'b1;
              resp_v_r    <= 1'b0;
              resp_last_r <= 1'b0;
            end else begin
              cnt_r       <= cnt_r + 1'b1;
              resp_last_r <= ((cnt_r + 1'b1) == (n_beats - 1'b1));
            end
          end
        end
        default: state_r <= e_ready;
      endcase
    end
  end

  assign resp_is_read = bp_me_is_read(hdr_r.msg_type);

  assign mem_cmd_ready_and_o = cmd_ready_r;
  assign mem_resp_header_o   = hdr_r;
  assign mem_resp_data_o     = (resp_v_r && resp_is_read) ? r_bytes : '0;
  assign mem_resp_v_o        = resp_v_r;
  assign mem_resp_last_o     = resp_last_r;
  assign error_o             = error_r;

endmodule

// File: doc/bp_me_stream_mem_responder.md
BP_ME_STREAM_MEM_RESPONDER -- requirements
Module: bp_me_stream_mem_responder

Interface
REQ-001 Parameters SHALL be:
- bp_params_p, default e_bp_default_cfg: supplies paddr_width_p, bedrock_data_width_p, mem_header_width_lp.
- mem_els_p, default 256: backing-store depth in bedrock_data_width_p words; power of two.
REQ-002 Ports SHALL be:
- clk_i  in  1  clock.
- reset_n_i  in  1  reset; asynchronous assert, active-low.
- mem_cmd_header_i  in  mem_header_width_lp  command header (msg_type, addr, size, payload).
- mem_cmd_data_i  in  bedrock_data_width_p  command data beat.
- mem_cmd_v_i  in  1  command beat valid.
- mem_cmd_ready_and_o  out  1  command beat accept.
- mem_cmd_last_i  in  1  final command beat.
- mem_resp_header_o  out  mem_header_width_lp  response header.
- mem_resp_data_o  out  bedrock_data_width_p  response data beat.
- mem_resp_v_o  out  1  response beat valid.
- mem_resp_ready_and_i  in  1  response beat accept.
- mem_resp_last_o  out  1  final response beat.
- error_o  out  1  sticky unsupported-opcode flag.

Function
REQ-003 The block SHALL be the memory-side endpoint of the BedRock Stream CCE-MEM interface: it consumes mem_cmd and produces mem_resp.
REQ-004 A beat SHALL transfer only in a cycle where valid and ready_and are both 1 (ready&valid).
REQ-005 Beat count SHALL be N = max(1, (8 << size) / bedrock_data_width_p).
REQ-006 Word index SHALL be addr[log2(bytes/word)+:log2(mem_els_p)], where bytes/word = bedrock_data_width_p/8; the index wraps modulo mem_els_p.
REQ-007 Beat k SHALL access word (base & ~(N-1)) | ((base + k) & (N-1)), i.e. wrap within the size-aligned block, critical word first.
REQ-008 The FSM SHALL have three states:
- e_ready: mem_cmd_ready_and_o=1, mem_resp_v_o=0.
- e_write: mem_cmd_ready_and_o=1.
- e_resp: mem_cmd_ready_and_o=0, mem_resp_v_o=1.
REQ-009 In e_ready, an accepted e_bedrock_mem_wr or e_bedrock_mem_uc_wr beat SHALL write its data and latch the header.
- last=1 -> e_resp.
- last=0 -> e_write.
REQ-010 In e_write, each accepted beat SHALL write the next word per REQ-007; the beat with last=1 moves to e_resp.
REQ-011 A write response SHALL be one beat:
- header equal to the latched header;
- data 0;
- mem_resp_last_o=1.
REQ-012 Sub-word writes (8<<size < bedrock_data_width_p) SHALL update only the addressed bytes, byte-aligned by addr; other bytes are unchanged.
REQ-013 In e_ready, an accepted e_bedrock_mem_rd or e_bedrock_mem_uc_rd beat SHALL latch the header and move to e_resp.
- Read responses SHALL be N beats with header equal to the latched header.
- Data SHALL be a combinational read of the word for the current beat.
- For sub-word sizes, the addressed bytes SHALL be replicated across the beat.
- mem_resp_last_o=1 on beat N-1 only.
REQ-014 Any other msg_type SHALL be accepted and answered like a read of N beats of data 0, and SHALL set error_o.
REQ-015 The beat counter SHALL advance only on a transfer; after the final response beat transfers, the FSM returns to e_ready.
REQ-016 Back-to-back commands SHALL be accepted no earlier than the cycle after the final response beat transfers.
REQ-017 Minimum latency SHALL be one cycle, command-last accept to first response valid.
REQ-018 Response outputs SHALL hold stable while mem_resp_v_o=1 and mem_resp_ready_and_i=0.
REQ-019 Command beats with v=0 SHALL have no effect; mem_cmd_last_i on a non-final beat count is honoured, terminating the write early.

Reset
REQ-020 Asserting reset_n_i=0 SHALL immediately force:
- state e_ready;
- beat counter 0;
- error_o 0;
- mem_resp_v_o 0;
- mem_resp_last_o 0;
- mem_cmd_ready_and_o 0 while reset is held.
REQ-021 Memory contents SHALL NOT be reset.
REQ-022 Reset mid-transfer SHALL abandon the transfer; writes already completed remain.
REQ-023 mem_cmd_ready_and_o SHALL assert in the first cycle after deassertion.

Structure
REQ-024 The state enum bp_me_stream_mem_state_e and the beat-count function SHALL reside in bp_me_pkg.
- The header struct comes from the existing bedrock mem declaration macros.
REQ-025 One sub-module, bp_me_stream_mem_storage, SHALL hold the flop array:
- one write port with byte mask;
- one combinational read port.

Verification
REQ-026 The bench SHALL cover these directed scenarios (64-bit data width; B = bytes):
- 64B write to addr 0x40 (8 beats 0x1..0x8), then 64B read at 0x40 -> one write-response beat (last=1), then 8 read beats 0x1..0x8, last on beat 8.
- 64B read at 0x58 after the above -> data order 0x4,0x5,0x6,0x7,0x8,0x1,0x2,0x3.
- 1B uc_wr 0xAB to 0x43, then 8B uc_rd at 0x40 -> byte 3 = 0xAB, other bytes unchanged.
- mem_resp_ready_and_i held 0 for 5 cycles mid-read -> header/data/last stable; no beat skipped.
- AMO msg_type -> N zero-data beats, error_o=1 and sticky until reset.
- reset_n_i pulsed low during beat 3 of an 8-beat write -> outputs cleared asynchronously; the next read returns new data for beats 0-2 only.
